vram_scanout: RTL
=================

Name: vram_scanout

Overview:
- Display-side consumer of the 16x16 1-bit video RAM.
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Walks the RAM's shared x/y address, one cell per CELL_PX x CELL_PX pixel block, inside a fixed window.
- Converts each returned bit into 2-bit-per-channel RGB with sync and data-enable aligned to the pixel.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE_LOW, 1, polarity of hsync/vsync
- CELL_PX, 16, pixels per cell edge (>=2)
- X0, 192, first window column
- Y0, 112, first window line
- FG_RGB, 6'b111111, colour for bit=1
- BG_RGB, 6'b000000, colour for bit=0 inside window
- BORDER_RGB, 6'b010101, active-area colour outside window

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ram_read_data  in  1  RAM read data; registered in RAM, valid 1 cycle after address
- ram_x  out  4  RAM column address (cell)
- ram_y  out  4  RAM row address (cell)
- scan_active  out  1  high while scanout owns the RAM address; writers use the RAM only when low
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active video
- rgb  out  6  {r[1:0],g[1:0],b[1:0]}
- frame_start  out  1  one-cycle pulse with first active pixel of each frame

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- Reset values:
  - all counters 0
  - ram_x=0, ram_y=0, scan_active=0
  - hsync=vsync=inactive level (1 when SYNC_ACTIVE_LOW)
  - de=0, rgb=0, frame_start=0
  - pipeline registers cleared
- Counters:
  - h_cnt 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800; wraps to 0.
  - v_cnt 0..V_TOTAL-1, V_TOTAL=525; increments when h_cnt wraps.
- Sync:
  - hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Window (cycle t, counter state):
  - in_win_x = X0 <= h_cnt < X0+16*CELL_PX; in_win_y likewise with v_cnt and Y0.
  - Cell walk uses sub-counters, no divider.
  - cx_sub counts 0..CELL_PX-1 inside window; cx increments on cx_sub wrap; both cleared at h_cnt==X0.
  - cy_sub/cy advance on each line end inside window; both cleared when v_cnt==Y0 at h_cnt==0.
- Pipeline, total latency 3 clocks from counter state to pins:
  - t+1: ram_x<=cx, ram_y<=cy, scan_active<=in_win_x&&in_win_y. Outside window ram_x/ram_y<=0.
  - t+2: RAM returns ram_read_data; window/active/sync flags carried in a delay line.
  - t+3: rgb, de, hsync, vsync, frame_start registered together.
  - Colour selection at t+3:
    - rgb=FG_RGB or BG_RGB when in window and active, selected by the bit.
    - BORDER_RGB when active and outside the window.
    - 0 when blanking.
- frame_start asserts at the t+3 pin cycle corresponding to h_cnt=0, v_cnt=0; exactly once per 420000 clocks.
- Sync/de are never skewed relative to rgb; all pins share the 3-cycle delay.
- Elaboration check: X0+16*CELL_PX<=H_ACTIVE and Y0+16*CELL_PX<=V_ACTIVE, else $error.
- Reset mid-frame: all state returns to reset values immediately. After release, counting restarts at (0,0); the first frame_start appears 3 cycles later.
- ram_read_data is ignored (rgb not driven from it) whenever the delayed scan_active flag is low.

Decomposition:
- Shared header vga_timing_defs.vh:
  - 640x480 timing localparams
  - H_TOTAL/V_TOTAL
  - RGB field width (6)
  - sync polarity default
- Natural sub-module: vga_timing_gen. Contains h/v counters and raw hsync/vsync/active/frame-start flags at counter time.
- vram_scanout holds the cell walk, address registers, delay line and colour mux.

Test Plan:
1. Reset release, sample for 10 cycles -> all outputs at reset values while rst_n=0; hsync=vsync=1 after.
2. Free-run one frame -> hsync low for exactly 96 cycles per 800-cycle line, starting 656 cycles after line start. vsync low for lines 490-491. de high 640 cycles/line on 480 lines. frame_start period 420000.
3. RAM model with only (x=0,y=0)=1 ->
   - output pixels x 192..207, lines 112..127 = 6'b111111
   - pixel (208,112) = 6'b000000
   - pixel (191,112) and (0,0) = 6'b010101
   - blanking pixels = 0
4. Address trace: counter at h_cnt=X0+3*CELL_PX, v_cnt=Y0+5*CELL_PX -> next cycle ram_x=3, ram_y=5, scan_active=1. At h_cnt=X0+256 -> ram_x=0, scan_active=0.
5. Checkerboard RAM (bit=x^y) -> every 16x16 block alternates FG/BG across all 256 cells; de/rgb edges coincide.
6. Assert rst_n low at line 200 pixel 300 for 3 cycles -> outputs reset asynchronously. After release frame_start fires 3 cycles later; timing matches scenario 2 from then on.

Source files
------------

// File: rtl/vram_scanout_pkg.sv
// Shared VGA timing defaults, widths and pipeline flag bundle for the VRAM scanout path.
package vram_scanout_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam bit SYNC_ACTIVE_LOW_DEF = 1'b1;
    localparam int RGB_W = 6;
    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    // Raw (active-high) timing flags carried alongside the pixel through the pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic fs;
    } flags_t;

endpackage

// File: rtl/vram_scanout_timing_gen.sv
// Free-running h/v counters with raw sync, active and frame-start flags at counter time.
module vram_scanout_timing_gen
    import vram_scanout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic hs_on,
    output logic vs_on,
    output logic active,
    output logic frame_first
);

    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
        end else begin
            h_cnt <= h_cnt + cnt_t'(1);
        end
    end

    assign hs_on       = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    assign vs_on       = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vram_scanout.sv
// Scans the 16x16 1-bit VRAM into a fixed window of a VGA frame; all pins share a 3-clock delay.
module vram_scanout
    import vram_scanout_pkg::*;
#(
    parameter int   H_ACTIVE        = H_ACTIVE_DEF,
    parameter int   H_FP            = H_FP_DEF,
    parameter int   H_SYNC          = H_SYNC_DEF,
    parameter int   H_BP            = H_BP_DEF,
    parameter int   V_ACTIVE        = V_ACTIVE_DEF,
    parameter int   V_FP            = V_FP_DEF,
    parameter int   V_SYNC          = V_SYNC_DEF,
    parameter int   V_BP            = V_BP_DEF,
    parameter bit   SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF,
    parameter int   CELL_PX         = 16,
    parameter int   X0              = 192,
    parameter int   Y0              = 112,
    parameter rgb_t FG_RGB          = 6'b111111,
    parameter rgb_t BG_RGB          = 6'b000000,
    parameter rgb_t BORDER_RGB      = 6'b010101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ram_read_data,
    output logic [3:0]       ram_x,
    output logic [3:0]       ram_y,
    output logic             scan_active,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start
);

    if ((X0 + 16 * CELL_PX > H_ACTIVE) || (Y0 + 16 * CELL_PX > V_ACTIVE) || (CELL_PX < 2)) begin : g_bad_window
        $error("vram_scanout: 16x16 cell window does not fit the active area");
    end

    localparam cnt_t WX_LO     = cnt_t'(X0);
    localparam cnt_t WX_HI     = cnt_t'(X0 + 16 * CELL_PX);
    localparam cnt_t WY_LO     = cnt_t'(Y0);
    localparam cnt_t WY_HI     = cnt_t'(Y0 + 16 * CELL_PX);
    localparam cnt_t CELL_LAST = cnt_t'(CELL_PX - 1);
    localparam cnt_t H_LAST    = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    function automatic logic sync_level(input logic on);
        return SYNC_ACTIVE_LOW ? ~on : on;
    endfunction

    function automatic rgb_t pick_rgb(input logic act, input logic win, input logic pix);
        if (!act) return '0;
        if (!win) return BORDER_RGB;
        return pix ? FG_RGB : BG_RGB;
    endfunction

    cnt_t   h_cnt, v_cnt;
    logic   hs_on, vs_on, active, frame_first;
    logic   in_win_x, in_win_y, in_win;
    cnt_t   cx_sub, cy_sub;
    logic [3:0] cx, cy;
    flags_t flags_p1, flags_p2;
    logic   win_p2;

    vram_scanout_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs_on       (hs_on),
        .vs_on       (vs_on),
        .active      (active),
        .frame_first (frame_first)
    );

    assign in_win_x = (h_cnt >= WX_LO) && (h_cnt < WX_HI);
    assign in_win_y = (v_cnt >= WY_LO) && (v_cnt < WY_HI);
    assign in_win   = in_win_x && in_win_y;

    // Cell walk: cleared whenever outside the window, so each window entry starts at cell 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_sub <= '0;
            cx     <= '0;
            cy_sub <= '0;
            cy     <= '0;
        end else begin
            if (!in_win_x) begin
                cx_sub <= '0;
                cx     <= '0;
            end else if (cx_sub == CELL_LAST) begin
                cx_sub <= '0;
                cx     <= cx + 4'd1;
            end else begin
                cx_sub <= cx_sub + cnt_t'(1);
            end
            if (h_cnt == H_LAST) begin
                if (!in_win_y) begin
                    cy_sub <= '0;
                    cy     <= '0;
                end else if (cy_sub == CELL_LAST) begin
                    cy_sub <= '0;
                    cy     <= cy + 4'd1;
                end else begin
                    cy_sub <= cy_sub + cnt_t'(1);
                end
            end
        end
    end

    // Stage 1: RAM address out, timing flags enter the delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_x       <= '0;
            ram_y       <= '0;
            scan_active <= 1'b0;
            flags_p1    <= '0;
        end else begin
            ram_x       <= in_win ? cx : 4'd0;
            ram_y       <= in_win ? cy : 4'd0;
            scan_active <= in_win;
            flags_p1    <= {hs_on, vs_on, active, frame_first};
        end
    end

    // Stage 2: RAM returns the bit for the stage-1 address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_p2 <= '0;
            win_p2   <= 1'b0;
        end else begin
            flags_p2 <= flags_p1;
            win_p2   <= scan_active;
        end
    end

    // Stage 3: every pin registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= sync_level(1'b0);
            vsync       <= sync_level(1'b0);
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= sync_level(flags_p2.hs);
            vsync       <= sync_level(flags_p2.vs);
            de          <= flags_p2.act;
            rgb         <= pick_rgb(flags_p2.act, win_p2, ram_read_data);
            frame_start <= flags_p2.fs;
        end
    end

endmodule
